// File: rtl/mio_bus_ctrl_if.sv
// CPU data-port request/response bundle between the CPU and mio_bus_ctrl.
interface mio_bus_ctrl_if;
  logic        CPU_MIO;
  logic        mem_w;
  logic [31:0] Addr_out;
  logic [31:0] Data_out;
  logic [31:0] Data_in;
  logic        MIO_ready;

  modport master (output CPU_MIO, mem_w, Addr_out, Data_out, input Data_in, MIO_ready);
  modport slave  (input CPU_MIO, mem_w, Addr_out, Data_out, output Data_in, MIO_ready);
endinterface

// File: rtl/mio_bus_ctrl.sv
// Memory/IO bus controller: decodes CPU accesses to RAM (with wait states), LED, switches
// and a down-counter. The counter peripheral is present only when MIO_COUNTER_EN is defined.
module mio_bus_ctrl #(
  parameter int unsigned RAM_WAIT = 1
) (
  input  logic          clk,
  input  logic          reset,
  mio_bus_ctrl_if.slave mio,
  output logic [9:0]    ram_addr,
  output logic          ram_we,
  output logic [31:0]   ram_din,
  input  logic [31:0]   ram_dout,
  output logic [7:0]    led,
  input  logic [15:0]   sw,
  output logic          counter_irq
);

  localparam int unsigned WAIT_W = 4;
  localparam logic [29:0] LED_WA = 30'h3C00_0000;
  localparam logic [29:0] SW_WA  = 30'h3C00_0001;
  localparam logic [29:0] CNT_WA = 30'h3C00_0002;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_e;

  state_e             state_q, state_d;
  logic [29:0]        addr_q, addr_d;
  logic               wr_q, wr_d;
  logic [31:0]        data_q, data_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               ready_q, ready_d;
  logic               ram_rd_q, ram_rd_d;
  logic [9:0]         ram_addr_q, ram_addr_d;
  logic               ram_we_q, ram_we_d;
  logic [31:0]        ram_din_q, ram_din_d;
  logic [7:0]         led_q, led_d;
  logic [31:0]        cnt_val;
  logic               cnt_wr_c;
  logic               unused_addr_lsb;

  assign unused_addr_lsb = ^mio.Addr_out[1:0];

  // Next-state and request handling; request fields are only latched in IDLE.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wr_d       = wr_q;
    data_d     = data_q;
    wait_d     = wait_q;
    rdata_d    = rdata_q;
    ready_d    = 1'b0;
    ram_rd_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_we_d   = 1'b0;
    ram_din_d  = ram_din_q;
    led_d      = led_q;
    cnt_wr_c   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (mio.CPU_MIO) begin
          addr_d  = mio.Addr_out[31:2];
          wr_d    = mio.mem_w;
          data_d  = mio.Data_out;
          rdata_d = '0;
          if (addr_d[29:10] == '0) begin
            if (RAM_WAIT == 0) begin
              state_d    = S_ACCESS;
              ram_addr_d = addr_d[9:0];
              ram_we_d   = wr_d;
              if (wr_d) ram_din_d = data_d;
            end else begin
              state_d = S_WAIT;
              wait_d  = WAIT_W'(RAM_WAIT - 1);
            end
          end else begin
            if (!wr_d) begin
              if (addr_d == LED_WA)      rdata_d = {24'b0, led_q};
              else if (addr_d == SW_WA)  rdata_d = {16'b0, sw};
              else if (addr_d == CNT_WA) rdata_d = cnt_val;
            end
            ready_d = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (wait_q == '0) begin
          state_d    = S_ACCESS;
          ram_addr_d = addr_q[9:0];
          ram_we_d   = wr_q;
          if (wr_q) ram_din_d = data_q;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
      S_ACCESS: begin
        state_d  = S_RESP;
        ready_d  = 1'b1;
        ram_rd_d = !wr_q;
      end
      S_RESP: begin
        state_d = S_IDLE;
        if (ram_rd_q) rdata_d = ram_dout;
        if (wr_q && addr_q == LED_WA) led_d = data_q[7:0];
        if (wr_q && addr_q == CNT_WA) cnt_wr_c = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      data_q     <= '0;
      wait_q     <= '0;
      rdata_q    <= '0;
      ready_q    <= 1'b0;
      ram_rd_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_we_q   <= 1'b0;
      ram_din_q  <= '0;
      led_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wr_q       <= wr_d;
      data_q     <= data_d;
      wait_q     <= wait_d;
      rdata_q    <= rdata_d;
      ready_q    <= ready_d;
      ram_rd_q   <= ram_rd_d;
      ram_addr_q <= ram_addr_d;
      ram_we_q   <= ram_we_d;
      ram_din_q  <= ram_din_d;
      led_q      <= led_d;
    end
  end

  // Synchronous RAM data only arrives in RESP, so it bypasses the read register there.
  assign mio.Data_in   = ram_rd_q ? ram_dout : rdata_q;
  assign mio.MIO_ready = ready_q;
  assign ram_addr      = ram_addr_q;
  assign ram_we        = ram_we_q;
  assign ram_din       = ram_din_q;
  assign led           = led_q;

`ifdef MIO_COUNTER_EN
  logic [31:0] cnt_q, cnt_d;
  logic        irq_q, irq_d;

  // A CNT write beats the same-cycle expiry, so the irq stays clear.
  always_comb begin
    cnt_d = cnt_q;
    irq_d = irq_q;
    if (cnt_wr_c) begin
      cnt_d = data_q;
      irq_d = 1'b0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 32'd1;
      if (cnt_q == 32'd1) irq_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      irq_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      irq_q <= irq_d;
    end
  end

  assign cnt_val     = cnt_q;
  assign counter_irq = irq_q;
`else
  logic unused_cnt_wr;
  assign unused_cnt_wr = cnt_wr_c;
  assign cnt_val       = '0;
  assign counter_irq   = 1'b0;
`endif

endmodule

// File: doc/mio_bus_ctrl.md
# mio_bus_ctrl

Memory/IO bus controller sitting directly downstream of the single-cycle CPU's data port. It accepts the CPU's `CPU_MIO`/`mem_w`/`Addr_out`/`Data_out` request, decodes it to data RAM or memory-mapped peripherals (LED register, switch port, down-counter), and returns `Data_in` with a one-cycle `MIO_ready` pulse. RAM accesses incur configurable wait states. The counter raises an interrupt that feeds the CPU's `INT` input.

## Interface
- `RAM_WAIT`, default 1: wait cycles inserted before each RAM access (0–15).
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `CPU_MIO`  in  1  CPU access request; held high until `MIO_ready`.
- `mem_w`  in  1  1 = write, 0 = read; sampled with the request.
- `Addr_out`  in  32  byte address; bits [1:0] are ignored.
- `Data_out`  in  32  write data.
- `Data_in`  out  32  read data to CPU; valid while `MIO_ready` = 1.
- `MIO_ready`  out  1  one-cycle completion pulse.
- `ram_addr`  out  10  RAM word address (`Addr_out[11:2]`).
- `ram_we`  out  1  RAM write strobe, one cycle.
- `ram_din`  out  32  RAM write data.
- `ram_dout`  in  32  RAM read data; synchronous, valid one cycle after the address.
- `led`  out  8  LED register.
- `sw`  in  16  switch inputs.
- `counter_irq`  out  1  sticky counter-expired interrupt.

## Operation
- Address map:
  - RAM: 0x0000_0000–0x0000_0FFF.
  - LED: 0xF000_0000. Read/write; a write sets `led <= Data_out[7:0]`; a read returns `{24'b0, led}`.
  - SW: 0xF000_0004. Read-only; returns `{16'b0, sw}`; writes are ignored.
  - CNT: 0xF000_0008. Read returns the current count; a write loads the count and clears `counter_irq`.
  - Unmapped addresses: reads return 0, writes are ignored, and `MIO_ready` is still pulsed.
- FSM states: IDLE, WAIT, ACCESS, RESP.
  - IDLE: on `CPU_MIO` = 1, latch the address, `mem_w` and `Data_out`, then decode.
    - IO or unmapped access: the read mux or register write is performed and the FSM goes to RESP.
    - RAM access: go to WAIT (or to ACCESS if `RAM_WAIT` = 0).
  - WAIT: count `RAM_WAIT` cycles, then go to ACCESS.
  - ACCESS: drive `ram_addr`; drive `ram_we` = 1 and `ram_din` for a write. Go to RESP.
  - RESP: `MIO_ready` = 1; `Data_in` is the registered read data (RAM reads capture `ram_dout` here). Return to IDLE.
- Request fields are latched only in IDLE. Changes on `Addr_out`, `Data_out` or `mem_w` mid-transaction have no effect.
- `CPU_MIO` still high in the IDLE cycle after RESP is treated as a new request. This permits back-to-back accesses with a one-cycle IDLE gap.
- Counter: 32-bit down counter.
  - Decrements every cycle while nonzero.
  - The 1→0 transition sets `counter_irq`, which stays set until a CNT write.
  - A CNT write in the same cycle as the 1→0 transition wins: the new value is loaded and the irq stays clear.
  - Writing 0 leaves the counter idle and clears the irq.

## Timing
- Reset values: `Data_in` = 0, `MIO_ready` = 0, `ram_we` = 0, `ram_addr` = 0, `ram_din` = 0, `led` = 0x00, counter = 0, `counter_irq` = 0, state = IDLE.
- IO access accepted in cycle N: `MIO_ready` = 1 in cycle N+1. Register writes take effect at the end of cycle N+1.
- RAM access accepted in cycle N:
  - Cycles N+1 … N+`RAM_WAIT`: WAIT.
  - Cycle N+`RAM_WAIT`+1: ACCESS.
  - Cycle N+`RAM_WAIT`+2: RESP.
  - With `RAM_WAIT` = 1, the ready pulse arrives 3 cycles after acceptance.
- `ram_we` is high for exactly one cycle per RAM write and never on a read.
- `reset` asserted mid-transaction aborts it immediately: no `ram_we` and no `MIO_ready` for the aborted request.

## Configuration
- `MIO_COUNTER_EN` defined: the counter peripheral and `counter_irq` are present as described above.
- `MIO_COUNTER_EN` undefined: 0xF000_0008 behaves as an unmapped address (read 0, write ignored, ready pulsed), and `counter_irq` is tied to 0.

## Test plan
- After reset, all outputs read 0. A LED write of 0x000000A5 to 0xF000_0000 gives `led` = 0xA5 and `MIO_ready` in cycle N+1. Reading back the same address returns 0x000000A5.
- With `sw` = 0x1234, a read of 0xF000_0004 returns `Data_in` = 0x00001234. A write to that address leaves all state unchanged.
- With `RAM_WAIT` = 1:
  - Write 0xDEADBEEF to 0x0000_0010: `ram_addr` = 4 and `ram_we` pulses once in cycle N+2; `MIO_ready` in N+3.
  - Read of 0x0000_0010 returns 0xDEADBEEF in N+3.
  - `Addr_out` changed mid-transaction has no effect.
- Write 3 to CNT: `counter_irq` rises 3 cycles later and stays high. Writing 5 in the same cycle the counter hits 0 keeps the irq low, and the count is 5.
- With `CPU_MIO` held high across 2 accesses, exactly 2 `MIO_ready` pulses occur with one IDLE cycle between them.
- Assert `reset` during WAIT of a RAM write: no `ram_we` and no `MIO_ready` appear. After release, the FSM is in IDLE and all outputs are 0.
